// File: rtl/trip_accumulator.sv
// trip_accumulator
//   Front end of the average-speed calculator. Turns the raw wheel reed-switch
//   level into trip distance (0.1 km units) and riding time (seconds). It also
//   produces the shared 1 Hz strobe. Riding time accrues only while the bike is
//   moving.
//
//   Ports
//     clk          system clock, rising edge
//     reset        synchronous, active-high reset
//     wheel_pulse  raw reed-switch level (asynchronous to clk)
//     trip_clr     single-cycle trip clear (already conditioned)
//     tick_1s      one-cycle pulse once per second
//     day          trip distance in 0.1 km, saturates at 9999
//     tim          riding time in seconds, saturates at 359999
//     moving       high while the motion FSM is in MOVING
//
//   Motion FSM
//     state   | meaning
//     STOPPED | no revolution for STOP_TIMEOUT_S whole seconds; time frozen
//     MOVING  | recent revolution seen; ticks accrue riding time
module trip_accumulator #(
  parameter int unsigned CLK_HZ         = 1000000,
  parameter int unsigned WHEEL_MM       = 2100,
  parameter int unsigned DEBOUNCE_CYC   = 1000,
  parameter int unsigned STOP_TIMEOUT_S = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wheel_pulse,
  input  logic        trip_clr,
  output logic        tick_1s,
  output logic [13:0] day,
  output logic [19:0] tim,
  output logic        moving
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DB_TC    = DW'(DEBOUNCE_CYC - 1);
  localparam logic [17:0]   WHEEL    = 18'(WHEEL_MM);
  localparam logic [17:0]   KM_TENTH = 18'd100000;
  localparam logic [13:0]   DAY_MAX  = 14'd9999;
  localparam logic [19:0]   TIM_MAX  = 20'd359999;
  localparam logic [3:0]    STOP_TC  = 4'(STOP_TIMEOUT_S);

  typedef enum logic {
    STOPPED = 1'b0,
    MOVING  = 1'b1
  } state_t;

  // input conditioning
  logic          sync1_q, sync2_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_q, db_d;
  logic          rev_q;

  // prescaler
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q;

  // distance / time
  logic [16:0]   mm_acc_q, mm_acc_d;
  logic [17:0]   mm_sum;
  logic [13:0]   day_q, day_d;
  logic [19:0]   tim_q, tim_d;

  // motion FSM
  state_t        state_q, state_d;
  logic [3:0]    idle_q, idle_d;

  // Debounce: the accepted level flips only after the synchronised level has
  // disagreed with it for DEBOUNCE_CYC consecutive cycles; agreement restarts.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_TC) begin
        db_d     = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  always_comb begin
    presc_d = (presc_q == PRESC_TC) ? '0 : presc_q + PW'(1);
  end

  // Distance and time. trip_clr wins over any coincident carry or increment.
  // Once day is pinned at its maximum the residue is frozen as well.
  always_comb begin
    mm_sum   = {1'b0, mm_acc_q} + WHEEL;
    mm_acc_d = mm_acc_q;
    day_d    = day_q;
    tim_d    = tim_q;
    if (trip_clr) begin
      mm_acc_d = '0;
      day_d    = '0;
      tim_d    = '0;
    end else begin
      if (rev_q && (day_q != DAY_MAX)) begin
        if (mm_sum >= KM_TENTH) begin
          mm_acc_d = 17'(mm_sum - KM_TENTH);
          day_d    = day_q + 14'd1;
        end else begin
          mm_acc_d = 17'(mm_sum);
        end
      end
      // Uses the pre-update state: the tick that stops us still counts, a
      // tick alongside the first rev from STOPPED does not.
      if (tick_q && (state_q == MOVING) && (tim_q < TIM_MAX)) begin
        tim_d = tim_q + 20'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    case (state_q)
      STOPPED: begin
        if (rev_q) begin
          state_d = MOVING;
          idle_d  = '0;
        end
      end
      MOVING: begin
        if (rev_q) begin
          idle_d = '0;
        end else if (tick_q) begin
          if ((idle_q + 4'd1) == STOP_TC) begin
            state_d = STOPPED;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = STOPPED;
        idle_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_cnt_q <= '0;
      db_q     <= 1'b0;
      rev_q    <= 1'b0;
      presc_q  <= '0;
      tick_q   <= 1'b0;
      mm_acc_q <= '0;
      day_q    <= '0;
      tim_q    <= '0;
      state_q  <= STOPPED;
      idle_q   <= '0;
    end else begin
      sync1_q  <= wheel_pulse;
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      db_q     <= db_d;
      rev_q    <= db_d & ~db_q;
      presc_q  <= presc_d;
      tick_q   <= (presc_q == PRESC_TC);
      mm_acc_q <= mm_acc_d;
      day_q    <= day_d;
      tim_q    <= tim_d;
      state_q  <= state_d;
      idle_q   <= idle_d;
    end
  end

  assign tick_1s = tick_q;
  assign day     = day_q;
  assign tim     = tim_q;
  assign moving  = (state_q == MOVING);

endmodule

// File: tb/tb_trip_accumulator.sv
// Bench for trip_accumulator. A main instance (CLK_HZ=100, DEBOUNCE_CYC=4,
// WHEEL_MM=2100) is compared every cycle against an event-level model. A second
// instance with a long wheel and short debounce reaches the day and time limits
// within a short run.
module tb_trip_accumulator;

  localparam int CLK  = 100;
  localparam int DEB  = 4;
  localparam int WMM  = 2100;
  localparam int STOP = 3;

  logic        clk;
  logic        reset, wheel_pulse, trip_clr;
  logic        tick_1s, moving;
  logic [13:0] day;
  logic [19:0] tim;

  logic        rst_s, wheel_s, clr_s;
  logic        tick_s, mov_s;
  logic [13:0] day_s;
  logic [19:0] tim_s;

  int checks   = 0;
  int failures = 0;

  trip_accumulator #(
    .CLK_HZ(CLK), .WHEEL_MM(WMM), .DEBOUNCE_CYC(DEB), .STOP_TIMEOUT_S(STOP)
  ) u_dut (
    .clk(clk), .reset(reset), .wheel_pulse(wheel_pulse), .trip_clr(trip_clr),
    .tick_1s(tick_1s), .day(day), .tim(tim), .moving(moving)
  );

  trip_accumulator #(
    .CLK_HZ(10), .WHEEL_MM(99999), .DEBOUNCE_CYC(1), .STOP_TIMEOUT_S(3)
  ) u_sat (
    .clk(clk), .reset(rst_s), .wheel_pulse(wheel_s), .trip_clr(clr_s),
    .tick_1s(tick_s), .day(day_s), .tim(tim_s), .moving(mov_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- event-level model of the main instance ----------------
  int     n;          // clock edges since reset released
  int     tick_cnt;
  int     hi_run, lo_run;
  bit     db_m;
  int     pend[$];    // edges at which a debounced revolution takes effect
  longint revs_m;     // revolutions since last clear
  longint tim_m;
  bit     mov_m;
  int     quiet_m;    // ticks since the last revolution
  longint day_m;
  bit     tick_eff, rev_eff;

  initial begin
    n = 0; tick_cnt = 0; hi_run = 0; lo_run = 0; db_m = 0;
    revs_m = 0; tim_m = 0; mov_m = 0; quiet_m = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        n = 0; hi_run = 0; lo_run = 0; db_m = 0; pend.delete();
        revs_m = 0; tim_m = 0; mov_m = 0; quiet_m = 0;
      end else begin
        n++;
        // tick is visible after every CLK-th edge and acts on the one after
        tick_eff = (n > 1) && (((n - 1) % CLK) == 0);
        rev_eff  = 1'b0;
        if (pend.size() > 0 && pend[0] == n) begin
          rev_eff = 1'b1;
          void'(pend.pop_front());
        end
        if (trip_clr) begin
          revs_m = 0;
          tim_m  = 0;
        end else begin
          if (tick_eff && mov_m && tim_m < 359999) tim_m++;
          if (rev_eff) revs_m++;
        end
        if (rev_eff) begin
          mov_m   = 1;
          quiet_m = 0;
        end else if (tick_eff && mov_m) begin
          quiet_m++;
          if (quiet_m == STOP) mov_m = 0;
        end
        // A level seen on DEB consecutive edges is accepted; a new high level
        // produces a revolution that lands three edges after acceptance.
        if (wheel_pulse) begin
          hi_run++; lo_run = 0;
          if (!db_m && hi_run == DEB) begin
            db_m = 1;
            pend.push_back(n + 3);
          end
        end else begin
          lo_run++; hi_run = 0;
          if (db_m && lo_run == DEB) db_m = 0;
        end
        day_m = (revs_m * WMM) / 100000;
        if (day_m > 9999) day_m = 9999;
        if (tick_1s) tick_cnt++;
        chk("tick_1s", longint'(tick_1s), longint'((n % CLK) == 0));
        chk("day", longint'(day), day_m);
        chk("tim", longint'(tim), tim_m);
        chk("moving", longint'(moving), longint'(mov_m));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic rev_main(input int hi, input int lo);
    wheel_pulse = 1'b1;
    repeat (hi) @(negedge clk);
    wheel_pulse = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic rev_sat();
    wheel_s = 1'b1;
    repeat (2) @(negedge clk);
    wheel_s = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    reset = 1'b1; wheel_pulse = 1'b0; trip_clr = 1'b0;
    rst_s = 1'b1; wheel_s = 1'b0; clr_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tick", longint'(tick_1s), 0);
    chk("rst_day", longint'(day), 0);
    chk("rst_tim", longint'(tim), 0);
    chk("rst_moving", longint'(moving), 0);
    chk("rst_sat_day", longint'(day_s), 0);
    reset = 1'b0;
    rst_s = 1'b0;

    // idle: ticks at 100 and 200
    repeat (250) @(negedge clk);
    chk("idle_ticks", tick_cnt, 2);
    chk("idle_day", longint'(day), 0);
    chk("idle_moving", longint'(moving), 0);

    // distance: 47 revs short of 0.1 km, 48th carries, 96 give two
    repeat (47) rev_main(10, 10);
    chk("day_47", longint'(day), 0);
    chk("moving_47", longint'(moving), 1);
    rev_main(10, 10);
    chk("day_48", longint'(day), 1);
    chk("mm_48", longint'(u_dut.mm_acc_q), 800);
    repeat (48) rev_main(10, 10);
    chk("day_96", longint'(day), 2);

    // glitches rejected; bounced pulse gives exactly one revolution
    repeat (3) rev_main(3, 10);
    wheel_pulse = 1'b1; repeat (3) @(negedge clk);
    wheel_pulse = 1'b0; repeat (2) @(negedge clk);
    rev_main(5, 10);
    chk("mm_97", longint'(u_dut.mm_acc_q), 3700);

    // stop, clear, single revolution then silence
    repeat (500) @(negedge clk);
    chk("stopped", longint'(moving), 0);
    trip_clr = 1'b1; @(negedge clk); trip_clr = 1'b0;
    chk("clr_day", longint'(day), 0);
    chk("clr_tim", longint'(tim), 0);
    rev_main(10, 10);
    chk("one_rev_moving", longint'(moving), 1);
    repeat (400) @(negedge clk);
    chk("tim_3", longint'(tim), 3);
    chk("stop_after_3", longint'(moving), 0);
    repeat (500) @(negedge clk);
    chk("tim_hold", longint'(tim), 3);
    rev_main(10, 10);
    chk("restart_moving", longint'(moving), 1);

    // clear coincident with the 4->5 carry and a MOVING tick
    repeat (236) rev_main(10, 10);
    chk("day_238", longint'(day), 4);
    while ((n % CLK) != 94) @(negedge clk);
    wheel_pulse = 1'b1;
    repeat (6) @(negedge clk);
    trip_clr = 1'b1;
    @(negedge clk);
    trip_clr = 1'b0;
    repeat (3) @(negedge clk);
    wheel_pulse = 1'b0;
    repeat (10) @(negedge clk);
    chk("coinc_day", longint'(day), 0);
    chk("coinc_tim", longint'(tim), 0);
    chk("coinc_mm", longint'(u_dut.mm_acc_q), 0);
    chk("coinc_moving", longint'(moving), 1);
    repeat (48) rev_main(10, 10);
    chk("after_clr_day", longint'(day), 1);

    // day saturation on the long-wheel instance
    repeat (9999) rev_sat();
    repeat (4) @(negedge clk);
    chk("sat_day_9999revs", longint'(day_s), 9998);
    rev_sat();
    repeat (4) @(negedge clk);
    chk("sat_day_max", longint'(day_s), 9999);
    repeat (4) rev_sat();
    repeat (4) @(negedge clk);
    chk("sat_day_hold", longint'(day_s), 9999);

    // time saturation: preload just below the limit right after a tick
    k = 0;
    while (tick_s !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("sat_tick_seen", longint'(k < 20), 1);
    @(negedge clk);
    force u_sat.tim_q = 20'd359998;
    @(negedge clk);
    release u_sat.tim_q;
    chk("sat_tim_preload", longint'(tim_s), 359998);
    repeat (30) rev_sat();
    chk("sat_tim_max", longint'(tim_s), 359999);
    chk("sat_moving", longint'(mov_s), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
